midi_parser: RTL

//  Byte-level MIDI 1.0 channel-message parser that sits directly downstream of uart_rx.

---
 rtl/midi_parser.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/midi_parser.sv
// -----------------------------------------------------------------------------
// midi_parser
//   Byte-level MIDI 1.0 channel-message parser placed directly after uart_rx.
//   Reassembles channel messages (with running status), ignores realtime bytes,
//   swallows SysEx, and emits one decoded event per complete supported message:
//   note off / note on / control change / pitch bend / program change.
//
// Ports
//   CLK        in   1  system clock
//   RST        in   1  asynchronous reset, active-low
//   CE         in   1  clock enable; 0 freezes state, ignores DV, forces EV low
//   DV         in   1  byte valid strobe from uart_rx (one cycle per byte)
//   DI         in   8  received byte, sampled when CE & DV
//   EV         out  1  event strobe, one cycle, one clock after the final byte
//   EV_TYPE    out  3  0 note off, 1 note on, 2 ctrl change, 3 pitch bend,
//                      4 prog change
//   EV_CH      out  4  channel of the event
//   D1         out  7  note / controller / program / bend LSB
//   D2         out  7  velocity / value / bend MSB (0 for prog change)
//   DBG_STATE  out  2  parser state (0 IDLE, 1 WAIT_D1, 2 WAIT_D2, 3 SYSEX)
//
// Handshake: a byte is consumed in every cycle where CE & DV is high; there is
// no back-pressure, so the parser accepts a byte on every cycle if offered.
// -----------------------------------------------------------------------------
module midi_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       DV,
    input  logic [7:0] DI,
    output logic       EV,
    output logic [2:0] EV_TYPE,
    output logic [3:0] EV_CH,
    output logic [6:0] D1,
    output logic [6:0] D2,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    // Status kinds are the status byte bits [6:4]
    localparam logic [2:0] K_NOTE_OFF = 3'd0;
    localparam logic [2:0] K_NOTE_ON  = 3'd1;
    localparam logic [2:0] K_CTRL     = 3'd3;
    localparam logic [2:0] K_PROG     = 3'd4;
    localparam logic [2:0] K_CH_AT    = 3'd5;
    localparam logic [2:0] K_BEND     = 3'd6;

    state_t     state_q, state_d;
    logic [2:0] kind_q, kind_d;
    logic [3:0] ch_q, ch_d;
    logic       match_q, match_d;
    logic [6:0] hold_q, hold_d;
    logic       ev_q, ev_d;
    logic [2:0] ev_type_q, ev_type_d;
    logic [3:0] ev_ch_q, ev_ch_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] d2_q, d2_d;

    logic       accept;
    logic       complete;
    logic [6:0] cand_d1;
    logic [6:0] cand_d2;

    assign accept = CE & DV;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        ch_d      = ch_q;
        match_d   = match_q;
        hold_d    = hold_q;
        ev_d      = 1'b0;
        ev_type_d = ev_type_q;
        ev_ch_d   = ev_ch_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        complete  = 1'b0;
        cand_d1   = 7'd0;
        cand_d2   = 7'd0;

        if (accept) begin
            if (DI[7]) begin
                if (DI[7:3] == 5'b11111) begin
                    // Realtime 0xF8..0xFF: leaves every piece of state untouched
                end else if (DI == 8'hF0) begin
                    state_d = SYSEX;
                end else if (DI[7:4] == 4'hF) begin
                    // System common and EOX end running status
                    state_d = IDLE;
                end else begin
                    kind_d  = DI[6:4];
                    ch_d    = DI[3:0];
                    match_d = OMNI | (DI[3:0] == CHANNEL);
                    state_d = WAIT_D1;
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        if (kind_q == K_PROG || kind_q == K_CH_AT) begin
                            complete = 1'b1;
                            cand_d1  = DI[6:0];
                            cand_d2  = 7'd0;
                        end else begin
                            hold_d  = DI[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        complete = 1'b1;
                        cand_d1  = hold_q;
                        cand_d2  = DI[6:0];
                        state_d  = WAIT_D1;  // running status kept
                    end
                    default: ;               // IDLE / SYSEX drop data bytes
                endcase
            end
        end

        if (complete && match_q) begin
            case (kind_q)
                K_NOTE_OFF: begin ev_d = 1'b1; ev_type_d = 3'd0; end
                // Note on with velocity 0 is a note off by MIDI convention
                K_NOTE_ON:  begin ev_d = 1'b1; ev_type_d = (cand_d2 == 7'd0) ? 3'd0 : 3'd1; end
                K_CTRL:     begin ev_d = 1'b1; ev_type_d = 3'd2; end
                K_BEND:     begin ev_d = 1'b1; ev_type_d = 3'd3; end
                K_PROG:     begin ev_d = 1'b1; ev_type_d = 3'd4; end
                default:    ;                // aftertouch: framing only
            endcase
            if (ev_d) begin
                ev_ch_d = ch_q;
                d1_d    = cand_d1;
                d2_d    = cand_d2;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            kind_q    <= 3'd0;
            ch_q      <= 4'd0;
            match_q   <= 1'b0;
            hold_q    <= 7'd0;
            ev_q      <= 1'b0;
            ev_type_q <= 3'd0;
            ev_ch_q   <= 4'd0;
            d1_q      <= 7'd0;
            d2_q      <= 7'd0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            ch_q      <= ch_d;
            match_q   <= match_d;
            hold_q    <= hold_d;
            ev_q      <= ev_d;
            ev_type_q <= ev_type_d;
            ev_ch_q   <= ev_ch_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
        end
    end

    // The strobe is gated so a disabled block never presents an event
    assign EV        = ev_q & CE;
    assign EV_TYPE   = ev_type_q;
    assign EV_CH     = ev_ch_q;
    assign D1        = d1_q;
    assign D2        = d2_q;
    assign DBG_STATE = state_q;

endmodule
